// File: rtl/search_driver.sv
// search_driver: multi-lane brute-force search controller with a fixed-latency
// hash-emulation pipeline, target/limit capture and one-hot status reporting.
module search_driver #(
   parameter  int unsigned WIDTH      = 32,
   parameter  int unsigned LANES      = 4,
   parameter  int unsigned PIPE_DEPTH = 8,
   localparam int unsigned LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic              CLK,
   input  logic              CPU_RESETN,
   input  logic              enable_switch,
   input  logic [WIDTH-1:0]  target,
   input  logic [WIDTH-1:0]  limit,
   output logic              status_paused,
   output logic              status_warming,
   output logic              status_running,
   output logic              status_found,
   output logic              status_done,
   output logic [WIDTH-1:0]  found_value,
   output logic [LANE_W-1:0] found_lane,
   output logic [WIDTH-1:0]  progress
);

   // progress carries one extra bit so the final increment never wraps
   localparam int unsigned PW = WIDTH + 1;

   // one-hot encoding lets each status output be a direct register bit
   typedef enum logic [4:0] {
      PAUSED  = 5'b00001,
      WARMING = 5'b00010,
      RUNNING = 5'b00100,
      FOUND   = 5'b01000,
      DONE    = 5'b10000
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     prog_q;
   logic              issue_done_q;
   logic [WIDTH-1:0]  tgt_q, lim_q;
   logic [LANES-1:0]  vld_q  [PIPE_DEPTH];
   logic [WIDTH-1:0]  base_q [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] last_q;

   logic [LANES-1:0]  issue_vld;
   logic              issue_last;
   logic              match_any;
   logic [LANE_W-1:0] match_lane;
   logic              tail_vld, tail_vld_next, pipe_any, fresh;
   logic              advance, capture, found_load;

   // Build the batch to issue: lanes beyond the limit are invalid, and the
   // batch holding the limit is tagged as last.
   always_comb begin
      issue_vld  = '0;
      issue_last = 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
         issue_vld[i] = !issue_done_q && ((prog_q + PW'(i)) <= {1'b0, lim_q});
      end
      issue_last = !issue_done_q && ({1'b0, lim_q} < (prog_q + PW'(LANES)));
   end

   // Compare the pipeline tail against the captured target.
   always_comb begin
      match_any  = 1'b0;
      match_lane = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (vld_q[PIPE_DEPTH-1][i] &&
             ((base_q[PIPE_DEPTH-1] + WIDTH'(i)) == tgt_q)) begin
            match_any  = 1'b1;
            match_lane = LANE_W'(i);
         end
      end
   end

   // Occupancy summary used for fresh-start detection.
   always_comb begin
      pipe_any = 1'b0;
      for (int s = 0; s < int'(PIPE_DEPTH); s++) begin
         pipe_any = pipe_any | (|vld_q[s]);
      end
   end

   assign tail_vld = |vld_q[PIPE_DEPTH-1];
   assign fresh    = (prog_q == '0) && !pipe_any;

   // Validity the tail stage will hold after the next advancing edge.
   if (PIPE_DEPTH == 1) begin : g_tail_direct
      assign tail_vld_next = |issue_vld;
   end else begin : g_tail_shift
      assign tail_vld_next = |vld_q[PIPE_DEPTH-2];
   end

   // State register.
   always_ff @(posedge CLK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) state_q <= PAUSED;
      else             state_q <= state_d;
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_d    = state_q;
      advance    = 1'b0;
      capture    = 1'b0;
      found_load = 1'b0;
      unique case (state_q)
         PAUSED: begin
            if (enable_switch) begin
               state_d = tail_vld ? RUNNING : WARMING;
               capture = fresh;
            end
         end
         WARMING: begin
            if (!enable_switch) begin
               state_d = PAUSED;
            end else begin
               advance = 1'b1;
               if (tail_vld_next) state_d = RUNNING;
            end
         end
         RUNNING: begin
            if (!enable_switch) begin
               state_d = PAUSED;
            end else begin
               advance = 1'b1;
               if (match_any) begin
                  state_d    = FOUND;
                  found_load = 1'b1;
               end else if (tail_vld && last_q[PIPE_DEPTH-1]) begin
                  state_d = DONE;
               end
            end
         end
         default: ;
      endcase
   end

   // Capture, issue, pipeline shift and result latching.
   always_ff @(posedge CLK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         prog_q       <= '0;
         issue_done_q <= 1'b0;
         tgt_q        <= '0;
         lim_q        <= '0;
         last_q       <= '0;
         found_value  <= '0;
         found_lane   <= '0;
         for (int s = 0; s < int'(PIPE_DEPTH); s++) begin
            vld_q[s]  <= '0;
            base_q[s] <= '0;
         end
      end else begin
         if (capture) begin
            tgt_q <= target;
            lim_q <= limit;
         end
         if (advance) begin
            for (int s = int'(PIPE_DEPTH) - 1; s > 0; s--) begin
               vld_q[s]  <= vld_q[s-1];
               base_q[s] <= base_q[s-1];
               last_q[s] <= last_q[s-1];
            end
            vld_q[0]  <= issue_vld;
            base_q[0] <= prog_q[WIDTH-1:0];
            last_q[0] <= issue_last;
            if (!issue_done_q) prog_q <= prog_q + PW'(LANES);
            issue_done_q <= issue_done_q | issue_last;
         end
         if (found_load) begin
            found_value <= base_q[PIPE_DEPTH-1] + WIDTH'(match_lane);
            found_lane  <= match_lane;
         end
      end
   end

   assign status_paused  = state_q[0];
   assign status_warming = state_q[1];
   assign status_running = state_q[2];
   assign status_found   = state_q[3];
   assign status_done    = state_q[4];
   assign progress       = prog_q[WIDTH-1:0];

endmodule

// File: tb/tb_search_driver.sv
// Directed bench for search_driver with a result scoreboard.
module tb_search_driver;

   localparam int unsigned WIDTH      = 8;
   localparam int unsigned LANES      = 4;
   localparam int unsigned PIPE_DEPTH = 4;
   localparam int unsigned LANE_W     = 2;

   logic              CLK = 1'b0;
   logic              CPU_RESETN = 1'b0;
   logic              enable_switch = 1'b0;
   logic [WIDTH-1:0]  target = '0;
   logic [WIDTH-1:0]  limit = '0;
   logic              status_paused, status_warming, status_running;
   logic              status_found, status_done;
   logic [WIDTH-1:0]  found_value;
   logic [LANE_W-1:0] found_lane;
   logic [WIDTH-1:0]  progress;

   typedef struct {
      logic       found;
      logic [7:0] value;
      logic [1:0] lane;
      int         edges;
      logic [7:0] prog;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   search_driver #(.WIDTH(WIDTH), .LANES(LANES), .PIPE_DEPTH(PIPE_DEPTH)) dut (
      .CLK(CLK), .CPU_RESETN(CPU_RESETN), .enable_switch(enable_switch),
      .target(target), .limit(limit),
      .status_paused(status_paused), .status_warming(status_warming),
      .status_running(status_running), .status_found(status_found),
      .status_done(status_done), .found_value(found_value),
      .found_lane(found_lane), .progress(progress)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Expected outcome derived from batch index arithmetic.
   function automatic exp_t model(input int t, input int lim);
      exp_t e;
      int   k, kl, issued;
      kl      = lim >> 2;
      e.found = (t <= lim);
      k       = e.found ? (t >> 2) : kl;
      e.edges = k + int'(PIPE_DEPTH) + 1;
      e.value = e.found ? 8'(t) : 8'h00;
      e.lane  = e.found ? 2'(t & 3) : 2'b00;
      issued  = (e.edges < kl + 1) ? e.edges : kl + 1;
      e.prog  = 8'(issued * 4);
      return e;
   endfunction

   task automatic do_reset();
      @(negedge CLK);
      CPU_RESETN    = 1'b0;
      enable_switch = 1'b0;
      @(negedge CLK);
      CPU_RESETN = 1'b1;
   endtask

   // Reset, apply target/limit, enable and take edge S.
   task automatic start(input int t, input int lim, input bit push);
      do_reset();
      target = 8'(t);
      limit  = 8'(lim);
      if (push) sb.push_back(model(t, lim));
      enable_switch = 1'b1;
      step();
   endtask

   // Run advancing edges until a terminal state, then score against the queue.
   task automatic run_and_score(input string name, input int already);
      int   edges;
      exp_t e;
      edges = already;
      while (!(status_found || status_done) && edges < 300) begin
         step();
         edges++;
      end
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check({name, "_found"}, 32'(status_found), 32'(e.found));
         check({name, "_done"}, 32'(status_done), 32'(!e.found));
         check({name, "_edges"}, 32'(edges), 32'(e.edges));
         check({name, "_value"}, 32'(found_value), 32'(e.value));
         check({name, "_lane"}, 32'(found_lane), 32'(e.lane));
         check({name, "_progress"}, 32'(progress), 32'(e.prog));
      end
   endtask

   initial begin
      // reset state and basic warm-up timeline
      do_reset();
      check("rst_paused", 32'(status_paused), 32'd1);
      check("rst_warming", 32'(status_warming), 32'd0);
      check("rst_progress", 32'(progress), 32'd0);
      check("rst_found_value", 32'(found_value), 32'd0);
      check("rst_found_lane", 32'(found_lane), 32'd0);

      target = 8'h05;
      limit  = 8'hFF;
      sb.push_back(model(8'h05, 8'hFF));
      enable_switch = 1'b1;
      step();
      check("s_warming", 32'(status_warming), 32'd1);
      for (int e = 1; e <= 3; e++) begin
         step();
         check($sformatf("warm_e%0d", e), 32'(status_warming), 32'd1);
      end
      step();
      check("run_e4", 32'(status_running), 32'd1);
      run_and_score("t05", 4);

      // lowest and highest targets
      start(8'h00, 8'hFF, 1'b1);
      run_and_score("t00", 0);
      start(8'hFF, 8'hFF, 1'b1);
      run_and_score("tFF", 0);

      // target beyond limit ends in DONE, which ignores enable
      start(8'h40, 8'h1F, 1'b1);
      run_and_score("nolim", 0);
      enable_switch = 1'b0;
      step();
      step();
      enable_switch = 1'b1;
      step();
      check("done_hold", 32'(status_done), 32'd1);
      check("done_not_paused", 32'(status_paused), 32'd0);
      check("done_progress", 32'(progress), 32'h20);

      // pause mid-warmup holds progress, resume completes the search
      start(8'h05, 8'hFF, 1'b1);
      for (int e = 0; e < 3; e++) step();
      enable_switch = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         check($sformatf("pause_c%0d", c), 32'(status_paused), 32'd1);
         check($sformatf("pause_prog_c%0d", c), 32'(progress), 32'h0C);
      end
      enable_switch = 1'b1;
      step();
      check("resume_warming", 32'(status_warming), 32'd1);
      run_and_score("pause", 3);

      // target changes after capture are ignored
      start(8'h05, 8'hFF, 1'b1);
      target = 8'h02;
      run_and_score("tchg", 0);

      // asynchronous reset between edges while running
      start(8'h05, 8'hFF, 1'b0);
      for (int e = 0; e < 5; e++) step();
      check("pre_rst_running", 32'(status_running), 32'd1);
      #2;
      CPU_RESETN = 1'b0;
      #1;
      check("async_paused", 32'(status_paused), 32'd1);
      check("async_running", 32'(status_running), 32'd0);
      check("async_progress", 32'(progress), 32'd0);
      #1;
      CPU_RESETN = 1'b1;
      target = 8'h05;
      sb.push_back(model(8'h05, 8'hFF));
      step();
      check("rst_rewarm", 32'(status_warming), 32'd1);
      run_and_score("rerun", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/search_driver.md
# search_driver

Parametrised brute-force search controller, successor to the 8-bit single-lane counter driver. It issues batches of LANES consecutive candidates per cycle into a PIPE_DEPTH-stage hash-emulation pipeline and compares pipeline output against a captured target. It reports paused/warming/running/found/done status plus the found value, lane and progress for the board display layer. It sits between the switch/reset inputs and the seven-segment/LED drivers in the top level.

## Interface
- WIDTH, 32: candidate/target width in bits (≥ 4)
- LANES, 4: candidates per batch; power of two, 1..16
- PIPE_DEPTH, 8: pipeline stages between issue and compare (≥ 1)
- LANE_W, max(1, clog2(LANES)): derived width of found_lane
- CLK  in  1  system clock, rising edge
- CPU_RESETN  in  1  reset, asynchronous, active-low
- enable_switch  in  1  1 = advance search, 0 = pause
- target  in  WIDTH  value searched for; captured at fresh start
- limit  in  WIDTH  highest candidate searched (inclusive); captured at fresh start
- status_paused / status_warming / status_running / status_found / status_done  out  1 each  one-hot state
- found_value  out  WIDTH  matching candidate
- found_lane  out  LANE_W  lane that produced the match
- progress  out  WIDTH  base of next batch to issue

## Operation
- Reset (async, CPU_RESETN=0): state PAUSED (status_paused=1, others 0), found_value=0, found_lane=0, progress=0, all pipeline valid bits 0, issue_done=0, captured target/limit=0.
- Advancing edge: rising CLK with enable_switch=1 and state ∈ {WARMING, RUNNING}. Pipeline, progress and comparison change only on advancing edges; otherwise everything holds.
- Issue, each advancing edge while issue_done=0: lane i candidate = progress+i, valid iff candidate ≤ captured limit; batch enters stage 1; progress += LANES. If the batch contains limit, set issue_done; later issues insert all-invalid batches. progress arithmetic in WIDTH+1 bits internally, output truncated; no wrap possible.
- Compare, each advancing edge: any valid stage-PIPE_DEPTH lane equal to captured target → FOUND, latch found_value/found_lane. At most one lane can match.
- States:
  - PAUSED: enable=1 → WARMING if stage PIPE_DEPTH invalid, else RUNNING. If progress=0 and pipeline empty (fresh start), capture target and limit on this edge. No issue on this edge.
  - WARMING: enable=0 → PAUSED; stage PIPE_DEPTH becomes valid → RUNNING.
  - RUNNING: enable=0 → PAUSED; match → FOUND; issue_done and final valid batch compared without match → DONE.
  - FOUND, DONE: terminal until reset; enable ignored; outputs frozen.
- Match on the final batch → FOUND, never DONE.
- target/limit changes after capture are ignored until the next reset.

## Timing
- Edge S = PAUSED→WARMING edge. Batch k (0-based) is issued on advancing edge k+1 and reaches stage PIPE_DEPTH on advancing edge k+PIPE_DEPTH.
- status_warming→status_running on advancing edge PIPE_DEPTH.
- Target t: k = t>>log2(LANES). status_found and found_* are valid after advancing edge k+PIPE_DEPTH+1, provided t ≤ limit.
- No match: kl = limit>>log2(LANES). status_done rises after advancing edge kl+PIPE_DEPTH+1.
- Pause: status_paused rises on the first edge that samples enable=0. Latencies count advancing edges only.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
Use WIDTH=8, LANES=4, PIPE_DEPTH=4, limit=0xFF unless stated.
- target=0x05, enable rises and stays → warming for 3 edges after S, running from advancing edge 4, found after advancing edge 6, found_value=0x05, found_lane=1.
- target=0x00 → found after advancing edge 5, found_lane=0. target=0xFF → found after advancing edge 68, found_lane=3, progress=0x100 truncated to 0x00.
- limit=0x1F, target=0x40 → never found; status_done after advancing edge 12; progress=0x20 frozen; enable toggles have no effect.
- target=0x05, enable dropped after 3 advancing edges for 10 cycles → status_paused throughout, progress held at 0x0C; found after 3 more advancing edges (6 total).
- target changed from 0x05 to 0x02 one cycle after S → still found_value=0x05.
- CPU_RESETN pulsed low mid-RUNNING (asynchronous, between edges) → outputs immediately show paused=1, progress=0. Re-enable → fresh capture; target 0x05 found after 6 advancing edges.
